// File: rtl/ysyx_23060072_lsu_pkg.sv
// Shared types for the LSU local-memory slice: access sizes, FSM states,
// the captured request record and the byte-lane mask helper.
package ysyx_23060072_lsu_pkg;

  typedef enum logic [1:0] {
    LSU_B   = 2'b00,
    LSU_H   = 2'b01,
    LSU_W   = 2'b10,
    LSU_ILL = 2'b11
  } lsu_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic [31:0] addr;
    lsu_type_e   ty;
    logic        zext;
    logic        load;
    logic        store;
    logic [31:0] wdata;
  } lsu_req_t;

  function automatic logic [3:0] lane_mask(lsu_type_e ty, logic [1:0] off);
    case (ty)
      LSU_B:   lane_mask = 4'b0001 << off;
      LSU_H:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
      LSU_W:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060072_lsu_sram.sv
// Word-organised data memory: byte-enable synchronous write, asynchronous read.
module ysyx_23060072_lsu_sram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [31:0]                    wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_23060072_lsu_mem.sv
// Fixed-latency load/store unit backed by a local SRAM; one access in flight,
// with range/alignment checking and registered response outputs.
module ysyx_23060072_lsu_mem
  import ysyx_23060072_lsu_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        load_flag_i,
  input  logic        store_flag_i,
  input  logic [1:0]  LSU_type_i,
  input  logic        LSU_signed_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_imm_i,
  input  logic [31:0] store_data_i,
  output logic        resp_valid_o,
  output logic [31:0] wb_wdata_o,
  output logic        LSU_wb_flag_o,
  output logic        LSU_hold_flag_o,
  output logic        err_o,
  output logic [31:0] err_addr_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  lsu_state_e  state;
  logic [3:0]  cnt;
  lsu_req_t    req_q, req_live, cur;
  logic        accept, go_resp, err, in_range, misalign, we;
  logic [3:0]  be;
  logic [31:0] wdata_rep, rdata, shifted, ext;

  assign req_ready_o     = (state == S_IDLE);
  assign accept          = req_valid_i & req_ready_o & (load_flag_i | store_flag_i);
  assign LSU_hold_flag_o = ((state == S_IDLE) & req_valid_i & (load_flag_i | store_flag_i))
                         | (state == S_BUSY);

  always_comb begin
    req_live.addr  = operand_a_i + operand_imm_i;
    req_live.ty    = lsu_type_e'(LSU_type_i);
    req_live.zext  = LSU_signed_i;
    req_live.load  = load_flag_i;
    req_live.store = store_flag_i & ~load_flag_i;
    req_live.wdata = store_data_i;
  end

  // With LATENCY=1 the memory access happens in the accept cycle itself,
  // so the datapath works on live inputs in IDLE and the captured copy later.
  assign cur     = (state == S_IDLE) ? req_live : req_q;
  assign go_resp = ((state == S_IDLE) && accept && (LATENCY == 1))
                || ((state == S_BUSY) && (cnt == 4'd0));

  assign in_range = (cur.addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign misalign = ((cur.ty == LSU_H) && cur.addr[0])
                 || ((cur.ty == LSU_W) && (cur.addr[1:0] != 2'b00));
  assign err      = (cur.ty == LSU_ILL) || misalign || !in_range;

  assign be = lane_mask(cur.ty, cur.addr[1:0]);
  assign we = go_resp & cur.store & ~err & rst_n;

  always_comb begin
    case (cur.ty)
      LSU_B:   wdata_rep = {4{cur.wdata[7:0]}};
      LSU_H:   wdata_rep = {2{cur.wdata[15:0]}};
      default: wdata_rep = cur.wdata;
    endcase
  end

  ysyx_23060072_lsu_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .we    (we),
    .be    (be),
    .waddr (cur.addr[AW+1:2]),
    .wdata (wdata_rep),
    .raddr (cur.addr[AW+1:2]),
    .rdata (rdata)
  );

  assign shifted = rdata >> {cur.addr[1:0], 3'b000};

  // LSU_signed_i=1 selects zero-extension.
  always_comb begin
    case (cur.ty)
      LSU_B:   ext = cur.zext ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      LSU_H:   ext = cur.zext ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      req_q         <= '0;
      resp_valid_o  <= 1'b0;
      wb_wdata_o    <= 32'b0;
      LSU_wb_flag_o <= 1'b0;
      err_o         <= 1'b0;
      err_addr_o    <= 32'b0;
    end else begin
      resp_valid_o  <= go_resp;
      LSU_wb_flag_o <= go_resp & cur.load & ~err;
      wb_wdata_o    <= (go_resp & cur.load & ~err) ? ext : 32'b0;
      err_o         <= go_resp & err;
      err_addr_o    <= (go_resp & err) ? cur.addr : 32'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_q <= req_live;
            if (LATENCY == 1) begin
              state <= S_RESP;
            end else begin
              state <= S_BUSY;
              cnt   <= 4'(LATENCY - 2);
            end
          end
        end
        S_BUSY: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060072_lsu_mem.sv
// Drives a LATENCY=1 and a LATENCY=3 instance with shared stimulus and checks
// both against a byte-addressed reference memory.
module tb_ysyx_23060072_lsu_mem;

  localparam int          DW   = 64;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v1, v3, ld, st, sg;
  logic [1:0]  ty;
  logic [31:0] a, imm, sd;
  logic        rdy [2];
  logic        rsp [2];
  logic        wbf [2];
  logic        hold[2];
  logic        er  [2];
  logic [31:0] wb  [2];
  logic [31:0] ea  [2];
  int          lat [2] = '{1, 3};

  int total = 0;
  int bad   = 0;
  logic [7:0] mb [DW*4];

  ysyx_23060072_lsu_mem #(.DEPTH_WORDS(DW), .LATENCY(1), .BASE_ADDR(BASE)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(v1), .req_ready_o(rdy[0]),
    .load_flag_i(ld), .store_flag_i(st), .LSU_type_i(ty), .LSU_signed_i(sg),
    .operand_a_i(a), .operand_imm_i(imm), .store_data_i(sd),
    .resp_valid_o(rsp[0]), .wb_wdata_o(wb[0]), .LSU_wb_flag_o(wbf[0]),
    .LSU_hold_flag_o(hold[0]), .err_o(er[0]), .err_addr_o(ea[0])
  );

  ysyx_23060072_lsu_mem #(.DEPTH_WORDS(DW), .LATENCY(3), .BASE_ADDR(BASE)) u_l3 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(v3), .req_ready_o(rdy[1]),
    .load_flag_i(ld), .store_flag_i(st), .LSU_type_i(ty), .LSU_signed_i(sg),
    .operand_a_i(a), .operand_imm_i(imm), .store_data_i(sd),
    .resp_valid_o(rsp[1]), .wb_wdata_o(wb[1]), .LSU_wb_flag_o(wbf[1]),
    .LSU_hold_flag_o(hold[1]), .err_o(er[1]), .err_addr_o(ea[1])
  );

  function automatic int size_of(input logic [1:0] t);
    return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
  endfunction

  // Expected error flag and writeback value for an access at byte address ad.
  function automatic void model(input logic l, input logic [1:0] t, input logic z,
                                input logic [31:0] ad, output logic e, output logic [31:0] w);
    int n, off;
    n = size_of(t);
    e = (t == 2'd3) || ((ad % 32'(n)) != 0) || (ad < BASE) || ((ad - BASE) >= 32'(DW*4));
    w = 32'b0;
    if (l && !e) begin
      off = int'(ad - BASE);
      for (int i = 0; i < n; i++) w = w | (32'(mb[off+i]) << (8*i));
      if (n < 4 && !z && w[8*n-1]) w = w | (32'hFFFF_FFFF << (8*n));
    end
  endfunction

  function automatic void mstore(input logic [1:0] t, input logic [31:0] ad, input logic [31:0] dd);
    int n, off;
    n   = size_of(t);
    off = int'(ad - BASE);
    for (int i = 0; i < n; i++) mb[off+i] = 8'(dd >> (8*i));
  endfunction

  task automatic do_txn(input logic l, input logic s, input logic [1:0] t, input logic z,
                        input logic [31:0] aa, input logic [31:0] ii, input logic [31:0] dd,
                        output logic [31:0] got);
    logic e, fl, sl;
    logic [31:0] ew, ad;
    ad = aa + ii;
    fl = l | s;
    sl = s & ~l;
    model(l, t, z, ad, e, ew);
    got = 32'b0;
    @(negedge clk);
    ld = l; st = s; ty = t; sg = z; a = aa; imm = ii; sd = dd; v1 = 1'b1; v3 = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (hold[d] !== fl || rdy[d] !== 1'b1) begin
        bad++;
        $display("FAIL idle_hold dut%0d: hold=%b rdy=%b, want hold=%b rdy=1", d, hold[d], rdy[d], fl);
      end
    end
    @(posedge clk); #1;
    v1 = 1'b0; v3 = 1'b0;
    ld = 1'($urandom); st = 1'($urandom); ty = 2'($urandom); sg = 1'($urandom);
    a = $urandom; imm = $urandom; sd = $urandom;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      for (int d = 0; d < 2; d++) begin
        logic        r, xbusy, xrdy, xwbf, xer;
        logic [31:0] xwb, xea;
        r     = fl && (k == lat[d]);
        xbusy = fl && (k < lat[d]);
        xrdy  = !(fl && (k <= lat[d]));
        xwbf  = r && l && !e;
        xer   = r && e;
        xwb   = xwbf ? ew : 32'b0;
        xea   = xer ? ad : 32'b0;
        total++;
        if (rsp[d] !== r || wbf[d] !== xwbf || er[d] !== xer || rdy[d] !== xrdy ||
            hold[d] !== xbusy || wb[d] !== xwb || ea[d] !== xea) begin
          bad++;
          $display("FAIL txn dut%0d k=%0d addr=%h: rsp=%b wbf=%b err=%b rdy=%b hold=%b wb=%h ea=%h, want %b %b %b %b %b %h %h",
                   d, k, ad, rsp[d], wbf[d], er[d], rdy[d], hold[d], wb[d], ea[d],
                   r, xwbf, xer, xrdy, xbusy, xwb, xea);
        end
        if (d == 1 && k == 3) got = wb[1];
      end
    end
    @(posedge clk); #1;
    if (sl && !e) mstore(t, ad, dd);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; v1 = 1'b0; v3 = 1'b0; ld = 1'b0; st = 1'b0; ty = 2'd0; sg = 1'b0;
    a = 32'b0; imm = 32'b0; sd = 32'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (rsp[d] !== 1'b0 || wbf[d] !== 1'b0 || er[d] !== 1'b0 || hold[d] !== 1'b0 ||
          wb[d] !== 32'b0 || ea[d] !== 32'b0 || rdy[d] !== 1'b1) begin
        bad++;
        $display("FAIL reset dut%0d: rsp=%b wbf=%b err=%b hold=%b wb=%h ea=%h rdy=%b, want zeros and rdy=1",
                 d, rsp[d], wbf[d], er[d], hold[d], wb[d], ea[d], rdy[d]);
      end
    end
  endtask

  task automatic test_init;
    logic [31:0] g;
    for (int w = 0; w < DW; w++) do_txn(1'b0, 1'b1, 2'd2, 1'b0, BASE + 32'(w*4), 32'b0, $urandom, g);
  endtask

  task automatic test_directed;
    logic [31:0] g;
    do_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, g);
    do_txn(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h0, g);
    total++;
    if (g !== 32'hFFFF_FFDE) begin bad++; $display("FAIL lb_signed: got %h want ffffffde", g); end

    do_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 32'hAABBCCDD, g);
    do_txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h1A, 32'h8, 32'h5555_1234, g);
    do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, g);
    total++;
    if (g !== 32'h1234_CCDD) begin bad++; $display("FAIL sh_merge: got %h want 1234ccdd", g); end

    do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h06, 32'h0, 32'h0, g);
    do_txn(1'b1, 1'b0, 2'd1, 1'b0, 32'h01, 32'h0, 32'h0, g);
    do_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h06, 32'h0, 32'h1111_1111, g);
    do_txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h01, 32'h0, 32'h2222_2222, g);
    do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 32'h0, g);
    do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 32'h0, g);

    do_txn(1'b0, 1'b1, 2'd2, 1'b0, BASE + 32'(DW*4), 32'h0, 32'h3333_3333, g);
    do_txn(1'b1, 1'b0, 2'd2, 1'b0, BASE + 32'(DW*4), 32'h0, 32'h0, g);
    do_txn(1'b0, 1'b1, 2'd3, 1'b0, 32'h30, 32'h0, 32'h4444_4444, g);
    do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 32'h0, g);
    do_txn(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 32'h9999_9999, g);
    do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFF0, 32'h30, 32'h0, g);
    do_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h0, g);

    do_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h00, 32'h0, 32'h8001_0000, g);
    do_txn(1'b1, 1'b0, 2'd1, 1'b1, 32'h02, 32'h0, 32'h0, g);
    total++;
    if (g !== 32'h0000_8001) begin bad++; $display("FAIL lhu: got %h want 00008001", g); end
    do_txn(1'b1, 1'b0, 2'd1, 1'b0, 32'h02, 32'h0, 32'h0, g);
    total++;
    if (g !== 32'hFFFF_8001) begin bad++; $display("FAIL lh: got %h want ffff8001", g); end
  endtask

  task automatic test_reset_busy;
    logic [31:0] g;
    @(negedge clk);
    ld = 1'b0; st = 1'b1; ty = 2'd2; sg = 1'b0; a = 32'h40; imm = 32'h0; sd = 32'h5A5A_5A5A; v3 = 1'b1;
    @(posedge clk); #1 v3 = 1'b0;
    total++;
    if (hold[1] !== 1'b1 || rdy[1] !== 1'b0) begin
      bad++; $display("FAIL rst_busy_pre: hold=%b rdy=%b want 1 0", hold[1], rdy[1]);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rsp[1] !== 1'b0 || rdy[1] !== 1'b1 || hold[1] !== 1'b0) begin
      bad++; $display("FAIL rst_busy: rsp=%b rdy=%b hold=%b want 0 1 0", rsp[1], rdy[1], hold[1]);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rsp[1] !== 1'b0 || rdy[1] !== 1'b1) begin
      bad++; $display("FAIL rst_busy_post: rsp=%b rdy=%b want 0 1", rsp[1], rdy[1]);
    end
    do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, g);
  endtask

  task automatic test_back_to_back;
    logic e;
    logic [31:0] ew;
    model(1'b1, 2'd2, 1'b0, 32'h20, e, ew);
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      ld = 1'b1; st = 1'b0; ty = 2'd2; sg = 1'b0; a = 32'h18; imm = 32'h8; sd = 32'h0;
      if (d == 0) v1 = 1'b1; else v3 = 1'b1;
      for (int n = 0; n < 12; n++) begin
        logic r;
        @(posedge clk); #1;
        r = ((n % (lat[d] + 1)) == (lat[d] - 1));
        total++;
        if (rsp[d] !== r || wb[d] !== (r ? ew : 32'b0)) begin
          bad++;
          $display("FAIL b2b dut%0d n=%0d: rsp=%b wb=%h want %b %h", d, n, rsp[d], wb[d], r, r ? ew : 32'b0);
        end
      end
      v1 = 1'b0; v3 = 1'b0;
      repeat (4) @(posedge clk);
    end
  endtask

  task automatic test_random;
    logic [31:0] g, tgt, off;
    logic [1:0]  t;
    logic        l, s;
    int          kind, n;
    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(0, 7));
      l = (kind == 1) || (kind >= 2 && kind <= 4);
      s = (kind == 1) || (kind >= 5);
      t = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      n = size_of(t);
      tgt = BASE + 32'($urandom_range(0, DW*4 + 15));
      if ($urandom_range(0, 3) != 0) tgt = tgt & ~32'(n - 1);
      off = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 16)) : $urandom;
      do_txn(l, s, t, 1'($urandom), tgt - off, off, $urandom, g);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
